secuenciador_alu: RTL

//  Shares one combinational ALU (4-bit ALUControl, N/Z/V/C flags) between two requesters.

---
 rtl/secuenciador_alu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/secuenciador_alu.sv
// secuenciador_alu: shares one combinational ALU between two requesters.
// Round-robin arbitration picks a command in IDLE and latches it onto the
// ALU inputs. EXEC captures the ALU result, flags and accumulator. RESP
// holds the response until the consumer takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a requester; grant and ready are decided here
// EXEC  | alu_* stable; result/flags/acc are captured at the edge
// RESP  | rsp_valid high; rsp_* held until rsp_ready
module secuenciador_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_use_acc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_use_acc,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic         last_grant;
  logic         grant_id;
  logic         accept;
  logic         illegal_q;
  logic [3:0]   sel_op;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic         sel_use_acc;
  logic         sel_illegal;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  // Mux the granted requester's command fields.
  always_comb begin
    sel_op      = req0_op;
    sel_a       = req0_a;
    sel_b       = req0_b;
    sel_use_acc = req0_use_acc;
    if (grant_id) begin
      sel_op      = req1_op;
      sel_a       = req1_a;
      sel_b       = req1_b;
      sel_use_acc = req1_use_acc;
    end
  end

  // Codes 1110 and 1111 are not ALU operations.
  assign sel_illegal = (sel_op[3:1] == 3'b111);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // Command latch on handshake; alu_* hold their value between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      illegal_q   <= 1'b0;
      rsp_id      <= 1'b0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      alu_a       <= sel_use_acc ? acc : sel_a;
      alu_b       <= sel_b;
      alu_control <= sel_illegal ? 4'b0000 : sel_op;
      illegal_q   <= sel_illegal;
      rsp_id      <= grant_id;
      last_grant  <= grant_id;
    end
  end

  // Response and accumulator capture; an illegal op leaves acc untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      acc        <= '0;
    end else if (state == EXEC) begin
      if (illegal_q) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_n, alu_z, alu_v, alu_c};
        rsp_err    <= 1'b0;
        acc        <= alu_result;
      end
    end
  end

endmodule
